// File: rtl/rdata_last_tracker_pkg.sv
// Shared interconnect definitions used by the read-side rlast tracker and
// the write-side wlast logic.
package rdata_last_tracker_pkg;

    localparam int AXI_LEN_W     = 8;
    localparam int TRACKER_DEPTH = 4;

    typedef logic [AXI_LEN_W-1:0] axi_len_t;

endpackage

// File: rtl/rdata_last_tracker_len_fifo.sv
// In-order circular queue of burst lengths: one entry per accepted AR,
// the head is the burst currently returning R beats.
module len_fifo #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 8
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     push,
    input  logic                     pop,
    input  logic [LEN_W-1:0]         wr_data,
    output logic [LEN_W-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [LEN_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop in the same cycle frees the head slot, so a push while full is legal then.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is not reset; entries are only read once
    // count says they were written, so a reset would only cost flops.
    always_ff @(posedge ACLK) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/rdata_last_tracker.sv
// Tracks outstanding read bursts, counts R beats and generates master RLAST.
// Define RDATA_RLAST_CHECK_EN to compare the slave's RLAST against the count.
module rdata_last_tracker
    import rdata_last_tracker_pkg::*;
#(
    parameter int DEPTH = TRACKER_DEPTH,
    parameter int LEN_W = AXI_LEN_W
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     Enable,
    input  logic                     AR_Valid,
    input  logic                     AR_Ready,
    input  logic [LEN_W-1:0]         AR_Len,
    input  logic                     R_Valid,
    input  logic                     R_Ready,
    input  logic                     Slave_RLast,
    output logic                     Sel_M_AXI_rlast,
    output logic                     Burst_Done,
    output logic                     AR_Stall,
    output logic [$clog2(DEPTH):0]   Outstanding,
    output logic                     Len_Err,
    output logic                     Ovf_Err
);

    logic             push;
    logic             beat;
    logic             last_beat;
    logic             rlast_lvl;
    logic             full;
    logic             empty;
    logic             ovf_set;
    logic [LEN_W-1:0] head_len;
    logic [LEN_W-1:0] beat_cnt;

    assign push      = AR_Valid & AR_Ready & Enable;
    assign beat      = R_Valid & R_Ready & Enable;
    assign rlast_lvl = ~empty & (beat_cnt == head_len);
    assign last_beat = beat & rlast_lvl;

    len_fifo #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) u_len_fifo (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .push    (push),
        .pop     (last_beat),
        .wr_data (AR_Len),
        .head    (head_len),
        .full    (full),
        .empty   (empty),
        .count   (Outstanding)
    );

    assign Sel_M_AXI_rlast = rlast_lvl;
    assign AR_Stall        = full;

    always_comb begin
        // NOTE: default first so no path leaves ovf_set unassigned (no latch).
        ovf_set = 1'b0;
        if (push && full && !last_beat) ovf_set = 1'b1;
        if (beat && empty)              ovf_set = 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            beat_cnt   <= '0;
            Burst_Done <= 1'b0;
            Ovf_Err    <= 1'b0;
        end else begin
            Burst_Done <= last_beat;
            if (last_beat)
                beat_cnt <= '0;
            else if (beat && !empty)
                beat_cnt <= beat_cnt + LEN_W'(1);
            if (ovf_set) Ovf_Err <= 1'b1;
        end
    end

`ifdef RDATA_RLAST_CHECK_EN
    logic len_err;

    // Flags both an early slave RLAST and a missing one on the final beat.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            len_err <= 1'b0;
        else if (beat && !empty && (Slave_RLast != rlast_lvl))
            len_err <= 1'b1;
    end

    assign Len_Err = len_err;
`else
    logic unused_slave_rlast;

    assign unused_slave_rlast = Slave_RLast;
    assign Len_Err            = 1'b0;
`endif

endmodule
